// File: rtl/nv_nvdla_sdp_cmux_skid_if.sv
// Valid/ready/payload stream bundle used for the SDP input mux sources and output.
interface nv_nvdla_sdp_cmux_skid_if #(
  parameter int DATA_W = 514
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] pd;

  modport master (output valid, output pd, input  ready);
  modport slave  (input  valid, input  pd, output ready);
endinterface

// File: rtl/nv_nvdla_sdp_cmux_skid.sv
// SDP input mux: selects the flying (cacc) or memory-read (mrdma) stream per layer and
// forwards it through a registered 2-entry skid buffer, with layer done and perf counters.
module nv_nvdla_sdp_cmux_skid #(
  parameter int DATA_W = 514
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rst,
  nv_nvdla_sdp_cmux_skid_if.slave  cacc2sdp,
  nv_nvdla_sdp_cmux_skid_if.slave  sdp_mrdma2cmux,
  nv_nvdla_sdp_cmux_skid_if.master sdp_cmux2dp,
  input  logic                     reg2dp_op_en,
  input  logic                     reg2dp_flying_mode,
  input  logic                     reg2dp_perf_dma_en,
  output logic                     dp2reg_done,
  output logic [31:0]              dp2reg_cmux_stall,
  output logic [31:0]              dp2reg_cmux_beats
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              sel;
  logic [1:0]        occ_p1;
  logic [1:0]        occ_nxt;
  logic              full_p1;
  logic              wr_ptr_p1;
  logic              rd_ptr_p1;
  logic [DATA_W-1:0] skid_pd_p1 [2];

  logic              run;
  logic              op_load;
  logic              in_valid;
  logic [DATA_W-1:0] in_pd;
  logic              accept;
  logic              pop;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign run     = (state == RUN);
  assign op_load = reg2dp_op_en & (state == IDLE);

  assign in_valid = sel ? cacc2sdp.valid : sdp_mrdma2cmux.valid;
  assign in_pd    = sel ? cacc2sdp.pd    : sdp_mrdma2cmux.pd;

  // Readies depend only on registered state/full, never on downstream ready.
  assign cacc2sdp.ready       = run &  sel & ~full_p1;
  assign sdp_mrdma2cmux.ready = run & ~sel & ~full_p1;

  assign accept = in_valid & run & ~full_p1;
  assign pop    = sdp_cmux2dp.valid & sdp_cmux2dp.ready;

  assign sdp_cmux2dp.valid = (occ_p1 != 2'd0);
  assign sdp_cmux2dp.pd    = skid_pd_p1[rd_ptr_p1];

  assign occ_nxt = occ_p1 + {1'b0, accept} - {1'b0, pop};

  // Only the layer_end bit steers the FSM; data and line_end pass through untouched.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (reg2dp_op_en) state_nxt = RUN;
      RUN:     if (accept && in_pd[DATA_W-1]) state_nxt = DRAIN;
      DRAIN:   if (occ_nxt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: control state, occupancy and counters.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state             <= IDLE;
      sel               <= 1'b0;
      occ_p1            <= 2'd0;
      full_p1           <= 1'b0;
      wr_ptr_p1         <= 1'b0;
      rd_ptr_p1         <= 1'b0;
      dp2reg_done       <= 1'b0;
      dp2reg_cmux_beats <= 32'd0;
      dp2reg_cmux_stall <= 32'd0;
    end else begin
      state       <= state_nxt;
      occ_p1      <= occ_nxt;
      full_p1     <= (occ_nxt == 2'd2);
      dp2reg_done <= (state == DRAIN) && (occ_nxt == 2'd0);
      if (op_load) begin
        sel <= reg2dp_flying_mode;
      end
      if (accept) begin
        wr_ptr_p1 <= ~wr_ptr_p1;
      end
      if (pop) begin
        rd_ptr_p1 <= ~rd_ptr_p1;
      end
      if (op_load) begin
        dp2reg_cmux_beats <= 32'd0;
      end else if (pop) begin
        dp2reg_cmux_beats <= sat_inc(dp2reg_cmux_beats);
      end
      if (op_load && reg2dp_perf_dma_en) begin
        dp2reg_cmux_stall <= 32'd0;
      end else if (reg2dp_perf_dma_en && sdp_cmux2dp.valid && !sdp_cmux2dp.ready) begin
        dp2reg_cmux_stall <= sat_inc(dp2reg_cmux_stall);
      end
    end
  end

  // Skid storage: payload only, no reset needed.
  always_ff @(posedge nvdla_core_clk) begin
    if (accept) begin
      skid_pd_p1[wr_ptr_p1] <= in_pd;
    end
  end

endmodule
